hazard_stall_unit: RTL and testbench

- Pipeline hazard controller that drives the stall input of the program counter.
- Also drives the IF/ID flush and the ID/EX bubble-insert controls.
- Tracks the destination registers of instructions in EX and MEM in internal registers.
- Compares them against the source registers of the instruction in ID, then stalls, flushes or bubbles as required. Sits between decode and the PC / pipeline registers.

---
 rtl/hazard_stall_unit.sv | 120 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: RAW hazard detect, PC stall, IF/ID flush, ID/EX bubble.
// Optional macro HAZARD_FORWARDING_EN: only load-use stalls when defined.
//
// Ports:
//   clk, reset           clock, sync active-high reset
//   id_valid             ID holds a real instruction
//   id_rs, id_rt         ID source registers
//   id_uses_rs/rt        ID instruction reads rs/rt
//   id_dest              ID destination register
//   id_reg_write         ID instruction writes the regfile
//   id_mem_read          ID instruction is a load
//   branch_taken         EX resolved a taken branch/jump
//   stall                hold PC and IF/ID
//   ifid_flush           clear IF/ID on next edge
//   idex_bubble          load NOP into ID/EX on next edge
//   stall_cycles         saturating count of stall cycles
module hazard_stall_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              branch_taken,
  output logic              stall,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic [REG_AW-1:0] ex_dest;
  logic              ex_rw;
  logic              ex_mr;
  logic [REG_AW-1:0] mem_dest;
  logic              mem_rw;

  logic rs_ex, rt_ex;
  logic hz;
  logic load_ex;

  // $0 is hardwired, so it never creates a dependency.
  assign rs_ex = id_uses_rs && ex_rw &&
                 (id_rs == ex_dest) &&
                 (id_rs != '0);
  assign rt_ex = id_uses_rt && ex_rw &&
                 (id_rt == ex_dest) &&
                 (id_rt != '0);

`ifdef HAZARD_FORWARDING_EN
  // Results forward from EX/MEM; only a load
  // in EX is too late for its consumer.
  logic unused_mem;
  assign unused_mem = ^{mem_dest, mem_rw};
  assign hz = ex_mr && (rs_ex || rt_ex);
`else
  logic rs_mem, rt_mem;
  logic unused_mr;
  assign rs_mem = id_uses_rs && mem_rw &&
                  (id_rs == mem_dest) &&
                  (id_rs != '0);
  assign rt_mem = id_uses_rt && mem_rw &&
                  (id_rt == mem_dest) &&
                  (id_rt != '0);
  assign unused_mr = ex_mr;
  assign hz = rs_ex || rt_ex || rs_mem || rt_mem;
`endif

  // Flush outranks stall: the ID op is wrong-path.
  always_comb begin
    stall       = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    priority case (1'b1)
      branch_taken: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      (id_valid && hz): begin
        stall       = 1'b1;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign load_ex = id_valid && !stall && !branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_dest      <= '0;
      ex_rw        <= 1'b0;
      ex_mr        <= 1'b0;
      mem_dest     <= '0;
      mem_rw       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      mem_dest <= ex_dest;
      mem_rw   <= ex_rw;
      if (load_ex) begin
        ex_dest <= id_dest;
        ex_rw   <= id_reg_write;
        ex_mr   <= id_mem_read;
      end else begin
        ex_dest <= '0;
        ex_rw   <= 1'b0;
        ex_mr   <= 1'b0;
      end
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed bench for hazard_stall_unit.
// Runs a 2-bit counter instance and a default-width one side by side.
module tb_hazard_stall_unit;

`ifdef HAZARD_FORWARDING_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif
  localparam int LU  = FWD ? 1 : 2;
  localparam int RAW = FWD ? 0 : 2;
  localparam int GAP = FWD ? 0 : 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt;
  logic       id_reg_write, id_mem_read;
  logic       branch_taken;

  logic        stall, ifid_flush, idex_bubble;
  logic [1:0]  sc2;
  logic        stall_b, flush_b, bubble_b;
  logic [15:0] sc16;
  logic [5:0]  ob;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign ob = {stall, ifid_flush, idex_bubble,
               stall_b, flush_b, bubble_b};

  hazard_stall_unit #(.REG_AW(5), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest),
    .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read),
    .branch_taken(branch_taken),
    .stall(stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble),
    .stall_cycles(sc2)
  );

  hazard_stall_unit dut16 (
    .clk(clk), .reset(reset),
    .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest),
    .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read),
    .branch_taken(branch_taken),
    .stall(stall_b), .ifid_flush(flush_b),
    .idex_bubble(bubble_b),
    .stall_cycles(sc16)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic v,
    input logic [4:0] rs, rt,
    input logic urs, urt,
    input logic [4:0] d,
    input logic rw, mr, br
  );
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_dest      = d;
    id_reg_write = rw;
    id_mem_read  = mr;
    branch_taken = br;
    #1;
  endtask

  task automatic nop;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    nop();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    nop();
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_chk++;
    if ({ob, sc2, sc16} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset got %b/%0d/%0d want 0",
               ob, sc2, sc16);
    end
  endtask

  task automatic test_load_use;
    do_reset();
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0);
    n_chk++;
    if (ob !== 6'b000000) begin
      n_fail++;
      $display("FAIL lu_prod got %b want 0", ob);
    end
    tick();
    drive(1, 8, 0, 1, 0, 10, 1, 0, 0);
    for (int k = 0; k < LU; k++) begin
      n_chk++;
      if (ob !== 6'b101101) begin
        n_fail++;
        $display("FAIL lu_stall k=%0d got %b want 101101",
                 k, ob);
      end
      tick();
    end
    n_chk++;
    if (ob !== 6'b000000) begin
      n_fail++;
      $display("FAIL lu_release got %b want 0", ob);
    end
    n_chk++;
    if ({sc2, sc16} !== {2'(LU), 16'(LU)}) begin
      n_fail++;
      $display("FAIL lu_count got %0d/%0d want %0d",
               sc2, sc16, LU);
    end
    tick();
    nop();
  endtask

  task automatic test_alu_raw;
    do_reset();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
    tick();
    drive(1, 0, 9, 0, 1, 11, 1, 0, 0);
    for (int k = 0; k < RAW; k++) begin
      n_chk++;
      if (ob !== 6'b101101) begin
        n_fail++;
        $display("FAIL raw_stall k=%0d got %b want 101101",
                 k, ob);
      end
      tick();
    end
    n_chk++;
    if (ob !== 6'b000000) begin
      n_fail++;
      $display("FAIL raw_release got %b want 0", ob);
    end
    n_chk++;
    if ({sc2, sc16} !== {2'(RAW), 16'(RAW)}) begin
      n_fail++;
      $display("FAIL raw_count got %0d/%0d want %0d",
               sc2, sc16, RAW);
    end
    tick();
    nop();
  endtask

  task automatic test_gap;
    do_reset();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
    tick();
    drive(1, 3, 0, 1, 0, 12, 1, 0, 0);
    n_chk++;
    if (ob !== 6'b000000) begin
      n_fail++;
      $display("FAIL gap_indep got %b want 0", ob);
    end
    tick();
    drive(1, 0, 9, 0, 1, 13, 1, 0, 0);
    for (int k = 0; k < GAP; k++) begin
      n_chk++;
      if (ob !== 6'b101101) begin
        n_fail++;
        $display("FAIL gap_stall k=%0d got %b want 101101",
                 k, ob);
      end
      tick();
    end
    n_chk++;
    if (ob !== 6'b000000) begin
      n_fail++;
      $display("FAIL gap_release got %b want 0", ob);
    end
    n_chk++;
    if ({sc2, sc16} !== {2'(GAP), 16'(GAP)}) begin
      n_fail++;
      $display("FAIL gap_count got %0d/%0d want %0d",
               sc2, sc16, GAP);
    end
    tick();
    nop();
  endtask

  task automatic test_reg0;
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    drive(1, 0, 0, 1, 1, 14, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (ob !== 6'b000000) begin
        n_fail++;
        $display("FAIL reg0 k=%0d got %b want 0", k, ob);
      end
      tick();
    end
    n_chk++;
    if ({sc2, sc16} !== 18'd0) begin
      n_fail++;
      $display("FAIL reg0_count got %0d/%0d want 0",
               sc2, sc16);
    end
    nop();
  endtask

  task automatic test_branch;
    do_reset();
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0);
    tick();
    drive(0, 8, 0, 1, 0, 15, 1, 0, 0);
    n_chk++;
    if (ob !== 6'b000000) begin
      n_fail++;
      $display("FAIL invalid_id got %b want 0", ob);
    end
    tick();
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0);
    tick();
    drive(1, 8, 0, 1, 0, 15, 1, 0, 1);
    n_chk++;
    if (ob !== 6'b011011) begin
      n_fail++;
      $display("FAIL branch got %b want 011011", ob);
    end
    tick();
    nop();
    n_chk++;
    if ({sc2, sc16} !== 18'd0) begin
      n_fail++;
      $display("FAIL branch_count got %0d/%0d want 0",
               sc2, sc16);
    end
  endtask

  task automatic test_saturation;
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
    tick();
    for (int k = 2; k <= 5; k++) begin
      drive(1, 5'(k - 1), 0, 1, 0, 5'(k), 1, 1, 0);
      for (int j = 0; j < LU; j++) begin
        n_chk++;
        if (ob !== 6'b101101) begin
          n_fail++;
          $display("FAIL sat_stall k=%0d j=%0d got %b", k, j, ob);
        end
        tick();
      end
      n_chk++;
      if (ob !== 6'b000000) begin
        n_fail++;
        $display("FAIL sat_release k=%0d got %b", k, ob);
      end
      tick();
    end
    n_chk++;
    if ({sc2, sc16} !== {2'd3, 16'(4 * LU)}) begin
      n_fail++;
      $display("FAIL sat_count got %0d/%0d want 3/%0d",
               sc2, sc16, 4 * LU);
    end
    drive(1, 5, 0, 1, 0, 6, 1, 1, 0);
    n_chk++;
    if (ob !== 6'b101101) begin
      n_fail++;
      $display("FAIL pre_reset got %b want 101101", ob);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_chk++;
    if ({ob, sc2, sc16} !== 24'd0) begin
      n_fail++;
      $display("FAIL mid_reset got %b/%0d/%0d want 0",
               ob, sc2, sc16);
    end
    tick();
    nop();
  endtask

  initial begin
    reset = 1'b1;
    nop();
    test_reset();
    test_load_use();
    test_alu_raw();
    test_gap();
    test_reg0();
    test_branch();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
